pe_in_sequencer: RTL
====================

Name: pe_in_sequencer

Overview:
Producer side of the PE input-packet interface. Drives PE_IN_PACKET into PE_top / PE_POOL_top. Per command, it optionally broadcast-loads one kernel (KER_SZ weights) into the PE weight buffers. It then streams NWIN convolution windows of ICP_NUM-lane activations, tagging window ends CNN_FIN and the group end POOL_FIN. Sits between the activation/weight fetch logic and the PE array.

Parameters:
DATA_WID, 8, width of one weight / activation lane
ICP_NUM, 4, input-channel lanes per beat (width of A[] and wrb)
ADDR_B, 4, PE weight buffer address width
KER_SZ, 9, taps per convolution window (<= 2**ADDR_B)
NWIN_B, 3, width of the cfg_nwin field

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle command pulse, sampled only in IDLE
cfg_load_w  in  1  1 = load KER_SZ weights before streaming
cfg_nwin  in  NWIN_B  windows per pool group; 0 is treated as 1
w_valid  in  1  weight word valid
w_data  in  DATA_WID  weight word
w_ready  out  1  weight accepted when w_valid & w_ready
a_valid  in  1  activation beat valid
a_data  in  ICP_NUM*DATA_WID  lane i = a_data[i*DATA_WID +: DATA_WID]
a_ready  out  1  activation accepted when a_valid & a_ready
pe_in_pk  out  PE_IN_PACKET  registered packet to the PE
busy  out  1  high from the accepted start until done
done  out  1  one-cycle pulse, coincident with the POOL_FIN beat

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-low: reset==0 at posedge clk clears all state.
- Reset / idle outputs: PE_state=INVALID, A[*]=0, wrb=0, wrb_addr=0, wrb_data=0, rdb_addr=0, w_ready=0, a_ready=0, busy=0, done=0.
- Any cycle that does not carry a beat emits exactly these idle values.
- FSM states: IDLE, LOAD_W, STREAM.
- IDLE transitions:
  - start=1 latches cfg_load_w and nwin = max(cfg_nwin, 1).
  - Goes to LOAD_W if cfg_load_w=1, else to STREAM.
  - Clears tap_cnt and win_cnt.
  - Sets busy next cycle.
- LOAD_W:
  - w_ready=1 (combinational from state).
  - Each handshake registers a beat on the next edge: wrb={ICP_NUM{1'b1}}, wrb_addr=tap_cnt, wrb_data=w_data, PE_state=INVALID.
  - tap_cnt++ per handshake.
  - On the handshake with tap_cnt==KER_SZ-1: clear tap_cnt, go to STREAM.
  - w_valid low: idle beat, counters hold.
- STREAM:
  - a_ready=1.
  - Each handshake registers A[i]=lane i, rdb_addr=tap_cnt, wrb=0.
  - PE_state is:
    - POOL_FIN if tap_cnt==KER_SZ-1 and win_cnt==nwin-1;
    - else CNN_FIN if tap_cnt==KER_SZ-1;
    - else VALID.
  - tap_cnt wraps to 0 at KER_SZ-1; win_cnt increments on each wrap.
  - a_valid low: INVALID bubble beat, tap_cnt/win_cnt/rdb state hold. Bubbles are legal anywhere, including between the last VALID and the CNN_FIN/POOL_FIN beat.
- Group end:
  - The POOL_FIN beat and done=1 are driven in the same cycle.
  - The FSM returns to IDLE on that edge; busy=0 from the next cycle.
- Latency: exactly 1 cycle from handshake to packet. No backpressure from the PE. Throughput is 1 beat/cycle.
- start while busy is ignored; no queuing.
- Reset mid-operation: outputs take idle values on that edge, the FSM goes to IDLE, and the partial weight load / window is discarded.
- Width rules:
  - tap_cnt is ADDR_B bits.
  - win_cnt is NWIN_B bits; it never reaches nwin, so it cannot overflow.
  - No arithmetic is done on data; lanes pass through unchanged.

Decomposition:
- Shared package (existing PE package): PE_IN_PACKET, PE_STATE enum (INVALID, VALID, CNN_FIN, POOL_FIN). Add the SEQ_STATE enum (IDLE, LOAD_W, STREAM).
- One natural sub-module: pe_seq_counter, a tap/window counter pair with wrap and last-tap / last-window flags, instantiated once.

Test Plan:
- Weight load, start with cfg_load_w=1, cfg_nwin=1, w_data 01..09 back-to-back -> 9 beats with wrb=4'b1111, wrb_addr 0..8, wrb_data 01..09, then w_ready=0, a_ready=1.
- Single window:
  - Stimulus: a_data ramps A={30,20,10,00}+k for k=0..8.
  - Response: 8 VALID beats with rdb_addr 0..7, then POOL_FIN with A={38,28,18,08}, rdb_addr 8.
  - done=1 on that cycle; busy=0 next cycle.
- Two windows, cfg_load_w=0, cfg_nwin=2, 18 continuous beats -> beat 9 is CNN_FIN with rdb_addr 8, beat 18 is POOL_FIN, rdb_addr wraps 8->0 between them.
- Bubbles:
  - Stimulus: a_valid low for 3 cycles after tap 4.
  - Response: 3 INVALID beats with A=0; the next beat carries rdb_addr 5; the FIN position is unchanged.
- Corner cases: cfg_nwin=0 behaves as 1 (POOL_FIN on tap 8); a start pulse mid-STREAM has no effect on counters or busy.
- Mid-stream reset:
  - Stimulus: reset=0 at tap 3, then a new start.
  - Response: idle packet on the next edge, IDLE state; the new command restarts at rdb_addr 0.

Source files
------------

// File: rtl/pe_in_sequencer_pkg.sv
// Shared PE types: the input packet, PE beat states and the sequencer FSM encoding.
// Also holds the geometry parameters used by the input sequencer.
package pe_in_sequencer_pkg;

  localparam int unsigned DATA_WID = 8;
  localparam int unsigned ICP_NUM  = 4;
  localparam int unsigned ADDR_B   = 4;
  localparam int unsigned KER_SZ   = 9;
  localparam int unsigned NWIN_B   = 3;

  typedef enum logic [1:0] {
    INVALID  = 2'd0,
    VALID    = 2'd1,
    CNN_FIN  = 2'd2,
    POOL_FIN = 2'd3
  } PE_STATE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2
  } SEQ_STATE;

  typedef struct packed {
    PE_STATE                           PE_state;
    logic [ICP_NUM-1:0][DATA_WID-1:0]  A;
    logic [ICP_NUM-1:0]                wrb;
    logic [ADDR_B-1:0]                 wrb_addr;
    logic [DATA_WID-1:0]               wrb_data;
    logic [ADDR_B-1:0]                 rdb_addr;
  } PE_IN_PACKET;

  // A window count of zero is treated as a single window.
  function automatic logic [NWIN_B-1:0] eff_nwin(input logic [NWIN_B-1:0] n);
    return (n == '0) ? NWIN_B'(1) : n;
  endfunction

endpackage

// File: rtl/pe_in_sequencer_if.sv
// Command, weight/activation handshake and PE packet bundle of the input sequencer.
// master = sequencer side, slave = fetch/command environment.
interface pe_in_sequencer_if;
  import pe_in_sequencer_pkg::*;

  logic                         start;
  logic                         cfg_load_w;
  logic [NWIN_B-1:0]            cfg_nwin;
  logic                         w_valid;
  logic [DATA_WID-1:0]          w_data;
  logic                         w_ready;
  logic                         a_valid;
  logic [ICP_NUM*DATA_WID-1:0]  a_data;
  logic                         a_ready;
  PE_IN_PACKET                  pe_in_pk;
  logic                         busy;
  logic                         done;

  modport master (
    input  start, cfg_load_w, cfg_nwin, w_valid, w_data, a_valid, a_data,
    output w_ready, a_ready, pe_in_pk, busy, done
  );

  modport slave (
    output start, cfg_load_w, cfg_nwin, w_valid, w_data, a_valid, a_data,
    input  w_ready, a_ready, pe_in_pk, busy, done
  );

endinterface

// File: rtl/pe_in_sequencer_seq_counter.sv
// Tap / window counter pair: tap wraps at KER_SZ-1, window advances on each wrap
// when enabled. Flags are decoded combinationally from the counter registers.
module pe_seq_counter
  import pe_in_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               step,
  input  logic               count_win,
  input  logic [NWIN_B-1:0]  nwin,
  output logic [ADDR_B-1:0]  tap_cnt,
  output logic [NWIN_B-1:0]  win_cnt,
  output logic               last_tap_c,
  output logic               last_win_c
);

  assign last_tap_c = (tap_cnt == ADDR_B'(KER_SZ - 1));
  assign last_win_c = (win_cnt == (nwin - NWIN_B'(1)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      tap_cnt <= '0;
      win_cnt <= '0;
    end else if (clr) begin
      tap_cnt <= '0;
      win_cnt <= '0;
    end else if (step) begin
      if (last_tap_c) begin
        tap_cnt <= '0;
        // Last window wraps to zero so the counter never reaches nwin.
        if (count_win) win_cnt <= last_win_c ? '0 : win_cnt + NWIN_B'(1);
      end else begin
        tap_cnt <= tap_cnt + ADDR_B'(1);
      end
    end
  end

endmodule

// File: rtl/pe_in_sequencer.sv
// Producer side of the PE input-packet interface: optional broadcast weight load,
// then NWIN windows of ICP_NUM-lane activations tagged CNN_FIN / POOL_FIN.
module pe_in_sequencer
  import pe_in_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  pe_in_sequencer_if.master    bus
);

  SEQ_STATE           state, state_next;
  PE_IN_PACKET        pk_q, pk_next;
  logic               busy_q, busy_next;
  logic               done_q, done_next;
  logic [NWIN_B-1:0]  nwin_q, nwin_next;

  logic               cnt_clr, cnt_step, cnt_win;
  logic [ADDR_B-1:0]  tap_cnt;
  logic [NWIN_B-1:0]  win_cnt;
  logic               last_tap, last_win;

  pe_seq_counter u_cnt (
    .clk        (clk),
    .reset      (reset),
    .clr        (cnt_clr),
    .step       (cnt_step),
    .count_win  (cnt_win),
    .nwin       (nwin_q),
    .tap_cnt    (tap_cnt),
    .win_cnt    (win_cnt),
    .last_tap_c (last_tap),
    .last_win_c (last_win)
  );

  // Ready is decoded from the registered state only.
  assign bus.w_ready  = (state == LOAD_W);
  assign bus.a_ready  = (state == STREAM);
  assign bus.pe_in_pk = pk_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      pk_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      nwin_q <= NWIN_B'(1);
    end else begin
      state  <= state_next;
      pk_q   <= pk_next;
      busy_q <= busy_next;
      done_q <= done_next;
      nwin_q <= nwin_next;
    end
  end

  always_comb begin
    state_next = state;
    pk_next    = '0;
    done_next  = 1'b0;
    nwin_next  = nwin_q;
    cnt_clr    = 1'b0;
    cnt_step   = 1'b0;
    cnt_win    = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          nwin_next  = eff_nwin(bus.cfg_nwin);
          cnt_clr    = 1'b1;
          state_next = bus.cfg_load_w ? LOAD_W : STREAM;
        end
      end

      LOAD_W: begin
        if (bus.w_valid) begin
          pk_next.wrb      = '1;
          pk_next.wrb_addr = tap_cnt;
          pk_next.wrb_data = bus.w_data;
          cnt_step         = 1'b1;
          if (last_tap) state_next = STREAM;
        end
      end

      STREAM: begin
        if (bus.a_valid) begin
          for (int unsigned i = 0; i < ICP_NUM; i++) begin
            pk_next.A[i] = bus.a_data[i*DATA_WID +: DATA_WID];
          end
          pk_next.rdb_addr = tap_cnt;
          cnt_step         = 1'b1;
          cnt_win          = 1'b1;
          if (last_tap && last_win) begin
            pk_next.PE_state = POOL_FIN;
            done_next        = 1'b1;
            state_next       = IDLE;
          end else if (last_tap) begin
            pk_next.PE_state = CNN_FIN;
          end else begin
            pk_next.PE_state = VALID;
          end
        end
      end

      default: state_next = IDLE;
    endcase

    // Busy stays up through the cycle that carries done.
    busy_next = (state_next != IDLE) || done_next;
  end

endmodule
